// File: rtl/frame_receiver_pkg.sv
// frame_receiver_pkg: framing constants, status/error codes and the byte-wide CRC-8 step
package frame_receiver_pkg;
   localparam logic [7:0] SOF_BYTE = 8'hA5;
   localparam logic [7:0] CRC_POLY = 8'h07;
   localparam logic [7:0] CRC_INIT = 8'h00;
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RX = 2'b01;
   localparam logic [1:0] ST_OK = 2'b10;
   localparam logic [1:0] ST_ERR = 2'b11;
   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_LEN = 2'b01;
   localparam logic [1:0] ERR_CRC = 2'b10;
   localparam logic [1:0] ERR_TMO = 2'b11;
   typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CRC} state_t;
   function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      return c;
   endfunction
endpackage

// File: rtl/frame_receiver.sv
// frame_receiver: UART receive-side deframer (SOF | LEN | payload | CRC-8) with inter-byte timeout
module frame_receiver
   import frame_receiver_pkg::*;
#(
   parameter int MAX_LEN = 16,
   parameter int TIMEOUT_CYCLES = 104167
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_last,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic [1:0] status,
   output logic [7:0] ok_count
);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] MAX_B = 8'(MAX_LEN);
   state_t state;
   logic [7:0] crc, len, cnt;
   logic [TW-1:0] tmr;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= S_IDLE;
         crc <= CRC_INIT;
         len <= '0;
         cnt <= '0;
         tmr <= '0;
         out_data <= '0;
         out_valid <= 1'b0;
         out_last <= 1'b0;
         frame_ok <= 1'b0;
         frame_err <= 1'b0;
         err_code <= ERR_NONE;
         status <= ST_IDLE;
         ok_count <= '0;
      end else begin
         out_valid <= 1'b0;
         out_last <= 1'b0;
         frame_ok <= 1'b0;
         frame_err <= 1'b0;
         // a byte arriving on the expiry cycle takes priority over the timeout
         if (rx_done) begin
            tmr <= '0;
            case (state)
               S_IDLE:
                  if (rx_data == SOF_BYTE) begin
                     state <= S_LEN;
                     crc <= CRC_INIT;
                     status <= ST_RX;
                     err_code <= ERR_NONE;
                  end
               S_LEN:
                  if (rx_data == 8'd0 || rx_data > MAX_B) begin
                     frame_err <= 1'b1;
                     err_code <= ERR_LEN;
                     status <= ST_ERR;
                     state <= S_IDLE;
                  end else begin
                     len <= rx_data;
                     crc <= crc8_next(crc, rx_data);
                     cnt <= '0;
                     state <= S_PAYLOAD;
                  end
               S_PAYLOAD: begin
                  out_data <= rx_data;
                  out_valid <= 1'b1;
                  crc <= crc8_next(crc, rx_data);
                  cnt <= cnt + 8'd1;
                  out_last <= cnt == len - 8'd1;
                  state <= cnt == len - 8'd1 ? S_CRC : S_PAYLOAD;
               end
               default: begin
                  frame_ok <= rx_data == crc;
                  frame_err <= rx_data != crc;
                  ok_count <= rx_data == crc ? ok_count + 8'd1 : ok_count;
                  status <= rx_data == crc ? ST_OK : ST_ERR;
                  err_code <= rx_data == crc ? err_code : ERR_CRC;
                  state <= S_IDLE;
               end
            endcase
         end else if (state != S_IDLE) begin
            if (tmr == TMO_LAST) begin
               frame_err <= 1'b1;
               err_code <= ERR_TMO;
               status <= ST_ERR;
               state <= S_IDLE;
            end else begin
               tmr <= tmr + TW'(1);
            end
         end
      end
endmodule

// File: tb/tb_frame_receiver.sv
// tb_frame_receiver: directed and random frames against a byte-level scoreboard model
module tb_frame_receiver;
   localparam int MAX_LEN = 16;
   localparam int TMO = 40;
   typedef struct packed {logic [7:0] d; logic l;} byte_t;
   typedef struct packed {logic ok; logic err; logic [1:0] ec; logic [1:0] st; logic [7:0] cnt;} res_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic rx_done = 1'b0;
   logic [7:0] out_data, ok_count;
   logic out_valid, out_last, frame_ok, frame_err;
   logic [1:0] err_code, status;
   int checks = 0;
   int errors = 0;
   byte_t qb[$];
   res_t qr[$];
   int m_st = 0;
   logic [7:0] m_crc, m_len, m_cnt;
   logic [7:0] m_ok = 8'd0;
   logic [1:0] m_ec = 2'd0;
   frame_receiver #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
      .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
      .status(status), .ok_count(ok_count)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic logic [7:0] crc_model(input logic [7:0] c, input logic [7:0] d);
      logic fb;
      for (int i = 7; i >= 0; i--) begin
         fb = c[7] ^ d[i];
         c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return c;
   endfunction
   task automatic push_res(input logic ok, input logic [1:0] ec);
      m_ec = ec;
      qr.push_back('{ok: ok, err: ~ok, ec: ec, st: ok ? 2'b10 : 2'b11, cnt: m_ok});
   endtask
   task automatic model_byte(input logic [7:0] b);
      case (m_st)
         0: if (b == 8'hA5) begin m_st = 1; m_crc = 8'h00; m_ec = 2'd0; end
         1: if (b == 8'h00 || b > 8'(MAX_LEN)) begin
               push_res(1'b0, 2'b01);
               m_st = 0;
            end else begin
               m_len = b; m_cnt = 8'd0; m_crc = crc_model(m_crc, b); m_st = 2;
            end
         2: begin
               qb.push_back('{d: b, l: m_cnt == m_len - 8'd1});
               m_crc = crc_model(m_crc, b);
               if (m_cnt == m_len - 8'd1) m_st = 3;
               m_cnt++;
            end
         default: begin
               if (b == m_crc) begin m_ok++; push_res(1'b1, m_ec); end
               else push_res(1'b0, 2'b10);
               m_st = 0;
            end
      endcase
   endtask
   task automatic send_byte(input logic [7:0] b);
      model_byte(b);
      @(negedge clk);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      rx_data = $urandom;
   endtask
   task automatic send_frame(input logic [7:0] len, input logic corrupt);
      logic [7:0] c;
      logic [7:0] p;
      send_byte(8'hA5);
      send_byte(len);
      if (len == 8'd0 || len > 8'(MAX_LEN)) return;
      c = crc_model(8'h00, len);
      for (int i = 0; i < int'(len); i++) begin
         p = 8'($urandom);
         c = crc_model(c, p);
         send_byte(p);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      send_byte(corrupt ? c ^ 8'(1 << $urandom_range(0, 7)) : c);
   endtask
   always @(negedge clk) if (!reset) begin
      byte_t eb;
      res_t er;
      if (frame_ok | frame_err) check("ok_err_excl", 32'(frame_ok & frame_err), 32'd0);
      if (out_valid) begin
         check("byte_expected", 32'(qb.size() > 0), 32'd1);
         if (qb.size() > 0) begin
            eb = qb.pop_front();
            check("payload", 32'({out_data, out_last}), 32'(eb));
         end
      end
      if (frame_ok | frame_err) begin
         check("result_expected", 32'(qr.size() > 0), 32'd1);
         if (qr.size() > 0) begin
            er = qr.pop_front();
            check("result", 32'({frame_ok, frame_err, err_code, status, ok_count}), 32'(er));
         end
      end
   end
   initial begin
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({out_data, out_valid, out_last, frame_ok, frame_err, err_code, status, ok_count}), 32'd0);
      reset = 1'b0;
      send_byte(8'h00);
      send_frame(8'h00, 1'b0);
      // directed frames with known CRCs
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h15);
      check("t1_status", 32'(status), 32'd2);
      check("t1_ok_count", 32'(ok_count), 32'd1);
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h00); send_byte(8'hC3);
      check("t2_ok_count", 32'(ok_count), 32'd2);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h16);
      check("t3_err_code", 32'(err_code), 32'd2);
      check("t3_ok_count", 32'(ok_count), 32'd2);
      send_byte(8'hA5); send_byte(8'h00);
      check("t4_len0", 32'({err_code, status}), 32'b0111);
      send_byte(8'hA5); send_byte(8'h11);
      check("t4_len17", 32'({err_code, status}), 32'b0111);
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'hA5);
      check("t4_len16_rx", 32'({err_code, status}), 32'b0001);
      reset = 1'b1; @(negedge clk); reset = 1'b0;
      m_st = 0; m_ok = 8'd0; m_ec = 2'd0; qb.delete();
      send_byte(8'h33); send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h15);
      check("t4_after_noise", 32'(ok_count), 32'd1);
      // timeout: error exactly TMO clocks after the last sampled byte
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01);
      push_res(1'b0, 2'b11);
      m_st = 0;
      repeat (TMO - 1) @(posedge clk);
      #1 check("t5_no_early_tmo", 32'(frame_err), 32'd0);
      @(posedge clk);
      #1 check("t5_tmo", 32'({frame_err, err_code, status}), 32'b11111);
      // a byte sampled on the expiry edge is accepted
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01);
      repeat (TMO - 2) @(negedge clk);
      send_byte(8'h00);
      send_byte(crc_model(crc_model(crc_model(8'h00, 8'h02), 8'h01), 8'h00));
      check("t5_expiry_byte", 32'({status, ok_count}), 32'({2'b10, m_ok}));
      // asynchronous reset mid-frame
      send_byte(8'hA5); send_byte(8'h02);
      check("t6_rx_status", 32'(status), 32'd1);
      #2 reset = 1'b1;
      #1 check("t6_async_reset", 32'({out_data, out_valid, out_last, frame_ok, frame_err, err_code, status, ok_count}), 32'd0);
      @(negedge clk) reset = 1'b0;
      m_st = 0; m_ok = 8'd0; m_ec = 2'd0;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h15);
      check("t6_after_reset", 32'({status, ok_count}), 32'h201);
      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(0, 3) == 0) send_byte(8'h5A ^ 8'($urandom_range(0, 15)));
         send_frame(8'($urandom_range(0, MAX_LEN + 2)), $urandom_range(0, 3) == 0);
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end
      repeat (5) @(negedge clk);
      check("rand_ok_count", 32'(ok_count), 32'(m_ok));
      check("bytes_drained", 32'(qb.size()), 32'd0);
      check("results_drained", 32'(qr.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
